// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, bidirectional serial shift and parallel load.
// A shift counter pulses frame_done once for every WIDTH shifts.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdata_in,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shifting;

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shifting = 1'b0;
    if (en) begin
      unique case (mode)
        2'b00: ;
        2'b01: begin
          q_d      = {sin_r, q_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        2'b10: begin
          q_d      = {q_q[WIDTH-2:0], sin_l};
          shifting = 1'b1;
        end
        2'b11: begin
          q_d   = pdata_in;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Either shift direction advances the frame; the count wraps instead of reaching WIDTH.
    if (shifting) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q          = q_q;
  assign sout_r     = q_q[0];
  assign sout_l     = q_q[WIDTH-1];
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: the next generation of the team's 4-bit serial-in/serial-out shifter. It adds configurable width, bidirectional serial shifting, parallel load, hold and clock enable, plus a shift counter that flags each completed frame of WIDTH shifts. It sits between serial links (UART/SPI-style bit streams) and parallel datapaths, serving as a SISO, SIPO, PISO or PIPO stage.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), width of the shift counter; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0 all state holds.
- mode  input  2  00 hold, 01 shift right (toward bit 0), 10 shift left (toward bit WIDTH-1), 11 parallel load.
- sin_r  input  1  serial input entering bit WIDTH-1 on a right shift.
- sin_l  input  1  serial input entering bit 0 on a left shift.
- pdata_in  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents (parallel out).
- sout_r  output  1  serial out for right shift, equal to q[0].
- sout_l  output  1  serial out for left shift, equal to q[WIDTH-1].
- shift_cnt  output  CNT_W  shifts completed in the current frame, 0..WIDTH-1.
- frame_done  output  1  one-cycle pulse after the WIDTH-th shift of a frame.

## Operation
- All state updates occur on the rising edge of clk. Priority: rst > en=0 > mode.
- Reset: q=0, shift_cnt=0, frame_done=0. As a result, sout_r=0 and sout_l=0.
- en=0: q and shift_cnt hold; frame_done=0.
- mode 00 (hold): q and shift_cnt hold; frame_done=0.
- mode 01 (shift right): q <= {sin_r, q[WIDTH-1:1]}. With a constant mode of 01, this matches the legacy SISO behaviour, with serial data in at the MSB and out at sout_r.
- mode 10 (shift left): q <= {q[WIDTH-2:0], sin_l}.
- mode 11 (load): q <= pdata_in; shift_cnt <= 0; frame_done <= 0. A load always starts a new frame.
- Shift counting (modes 01 and 10 only; direction does not matter):
  - If shift_cnt == WIDTH-1: shift_cnt <= 0 and frame_done <= 1.
  - Otherwise: shift_cnt <= shift_cnt+1 and frame_done <= 0.
- A mixed sequence of left and right shifts still counts toward one frame.
- The counter never reaches WIDTH; it wraps to 0 on the frame-completing shift.
- Reset mid-frame discards q and the count. The next frame starts from 0.

## Timing
- Latency: q reflects a shift or load one cycle after the sampling edge.
- sout_r and sout_l are combinational from q, so there is no extra delay.
- frame_done is registered. It is high for exactly the one cycle following the edge that performed the WIDTH-th shift.
- Back-to-back frames are supported: continuous shifting gives a frame_done pulse every WIDTH cycles with no gap.
- Simultaneous events:
  - rst=1 overrides en and mode.
  - Load on the cycle after frame_done simply restarts the frame; no special case is needed.
- No combinational path from inputs to outputs.

## Test plan
- Reset: drive arbitrary inputs, then apply rst=1 for 2 cycles. Require q=0, shift_cnt=0, frame_done=0, sout_r=0, sout_l=0.
- SISO equivalence (WIDTH=4): mode=01, en=1, feed sin_r=1,0,1,1 on successive edges. Require q=4'b1101 after the 4th edge. Require sout_r to read 1,0,1,1 over the next 4 edges with sin_r=0. Require a frame_done pulse after edges 4 and 8.
- PISO (WIDTH=8): load pdata_in=8'hA5, then shift right 8 times with sin_r=0.
  - Require sout_r sequence 1,0,1,0,0,1,0,1.
  - Require shift_cnt to step 0..7 then 0.
  - Require frame_done=1 only in the cycle after the 8th shift, and q=8'h00.
- SIPO left (WIDTH=8): shift left with sin_l=1,1,0,0,1,0,1,0. Require q=8'hCA and one frame_done pulse.
- Enable/hold: load 8'h3C, then apply en=0 for 3 cycles and mode=00 with en=1 for 3 cycles. Require q=8'h3C, shift_cnt unchanged, frame_done=0 throughout.
- Mid-frame disruption:
  - After 5 shifts, apply load 8'hFF. Require shift_cnt=0, and 8 further shifts are needed for frame_done.
  - Repeat with rst after 5 shifts. Require q=0 and shift_cnt=0, with no frame_done pulse.
